nora_cpu_membus: RTL and testbench

Cycle sequencer between the 65C02/65C816 CPU bus and the external SRAM and I/O chip-selects inside NORA. It generates the CPU clock CPHI2 from the fast system clock and decodes each CPU cycle's address through the RAMBANK/ROMBANK registers at $0000/$0001. It drives MAH[20:12] and the SRAM strobes (M1CSn/MRDn/MWRn), steers read data back onto CD, and emits the VIA/VERA/AIO selects.

---
 rtl/nora_membus_pkg.sv | 35 +++
 rtl/nora_cpu_membus_if.sv | 40 ++++
 rtl/nora_addr_decode.sv | 45 ++++
 rtl/nora_cpu_membus.sv | 176 +++++++++++++++++
 tb/tb_nora_cpu_membus.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/nora_membus_pkg.sv
// Shared definitions for the NORA CPU memory-bus sequencer.
//   - CPU address windows for the bank registers, I/O page, banked RAM and ROM
//   - target_t: what a decoded CPU cycle talks to
//   - MAH prefixes that select the low RAM, banked RAM and ROM regions of SRAM
package nora_membus_pkg;

    typedef enum logic [2:0] {
        T_SRAM,
        T_RAMBANK,
        T_ROMBANK,
        T_VIA,
        T_VERA,
        T_AIO,
        T_NONE
    } target_t;

    localparam logic [15:0] RAMBANK_ADDR = 16'h0000;
    localparam logic [15:0] ROMBANK_ADDR = 16'h0001;
    localparam logic [15:0] IO_BASE      = 16'h9F00;
    localparam logic [15:0] VIA_LAST     = 16'h9F0F;
    localparam logic [15:0] VERA_BASE    = 16'h9F20;
    localparam logic [15:0] VERA_LAST    = 16'h9F3F;
    localparam logic [15:0] AIO_BASE     = 16'h9F40;
    localparam logic [15:0] AIO_LAST     = 16'h9F5F;
    localparam logic [15:0] BANKRAM_BASE = 16'hA000;
    localparam logic [15:0] ROM_BASE     = 16'hC000;

    localparam logic [4:0] MAH_LOW_PFX     = 5'b00000;
    localparam logic [1:0] MAH_BANKRAM_PFX = 2'b01;
    localparam logic [1:0] MAH_ROM_PFX     = 2'b11;

    // Order of the I/O chip-selects as they are generated in the top level.
    localparam target_t IO_SEL_TGT [3] = '{T_VIA, T_VERA, T_AIO};

endpackage

// File: rtl/nora_cpu_membus_if.sv
// Bus bundle between the CPU/SRAM/I-O pins and the cycle sequencer.
//   master: the sequencer view (drives CPHI2, strobes, selects, data returns)
//   slave : the board/CPU view (drives address, R/W, data, run request)
interface nora_cpu_membus_if;
    logic        run_i;
    logic [15:0] ca_i;
    logic        crwn_i;
    logic [7:0]  cd_i;
    logic [7:0]  cd_o;
    logic        cd_oe_o;
    logic [7:0]  md_i;
    logic [7:0]  md_o;
    logic        md_oe_o;
    logic        cphi2_o;
    logic [8:0]  mah_o;
    logic        m1csn_o;
    logic        mrdn_o;
    logic        mwrn_o;
    logic        via_csn_o;
    logic        vera_csn_o;
    logic        aio_csn_o;
    logic [7:0]  io_rdata_i;
    logic [7:0]  rambank_o;
    logic [7:0]  rombank_o;
    logic        cyc_end_o;

    modport master (
        input  run_i, ca_i, crwn_i, cd_i, md_i, io_rdata_i,
        output cd_o, cd_oe_o, md_o, md_oe_o, cphi2_o, mah_o,
               m1csn_o, mrdn_o, mwrn_o, via_csn_o, vera_csn_o, aio_csn_o,
               rambank_o, rombank_o, cyc_end_o
    );

    modport slave (
        output run_i, ca_i, crwn_i, cd_i, md_i, io_rdata_i,
        input  cd_o, cd_oe_o, md_o, md_oe_o, cphi2_o, mah_o,
               m1csn_o, mrdn_o, mwrn_o, via_csn_o, vera_csn_o, aio_csn_o,
               rambank_o, rombank_o, cyc_end_o
    );
endinterface

// File: rtl/nora_addr_decode.sv
// Combinational CPU address decoder.
//   ca_i      : CPU address
//   rambank_i : RAMBANK bits used for the $A000-$BFFF window
//   rombank_i : ROMBANK bits used for the $C000-$FFFF window
//   target_o  : decoded target of the cycle
//   mah_o     : SRAM address bits 20:12 (zero for non-SRAM targets)
module nora_addr_decode
    import nora_membus_pkg::*;
(
    input  logic [15:0] ca_i,
    input  logic [5:0]  rambank_i,
    input  logic [4:0]  rombank_i,
    output target_t     target_o,
    output logic [8:0]  mah_o
);

    always_comb begin
        target_o = T_NONE;
        mah_o    = '0;
        if (ca_i == RAMBANK_ADDR) begin
            target_o = T_RAMBANK;
        end else if (ca_i == ROMBANK_ADDR) begin
            target_o = T_ROMBANK;
        end else if (ca_i < IO_BASE) begin
            target_o = T_SRAM;
            mah_o    = {MAH_LOW_PFX, ca_i[15:12]};
        end else if (ca_i < BANKRAM_BASE) begin
            // I/O page; gaps between the chip windows stay T_NONE (open bus)
            if (ca_i <= VIA_LAST) begin
                target_o = T_VIA;
            end else if (ca_i >= VERA_BASE && ca_i <= VERA_LAST) begin
                target_o = T_VERA;
            end else if (ca_i >= AIO_BASE && ca_i <= AIO_LAST) begin
                target_o = T_AIO;
            end
        end else if (ca_i < ROM_BASE) begin
            target_o = T_SRAM;
            mah_o    = {MAH_BANKRAM_PFX, rambank_i, ca_i[12]};
        end else begin
            target_o = T_SRAM;
            mah_o    = {MAH_ROM_PFX, rombank_i, ca_i[13:12]};
        end
    end

endmodule

// File: rtl/nora_cpu_membus.sv
// CPU cycle sequencer: derives CPHI2 from clk6x and turns each CPU cycle into
// SRAM strobes, I/O selects, bank-register accesses and CD read data.
//   clk6x, rst : system clock and synchronous active-high reset
//   bus        : nora_cpu_membus_if.master (CPU, SRAM and I/O side signals)
// Every output is registered and computed from the next-tick state, so the
// strobes change on the same edge as CPHI2.
module nora_cpu_membus
    import nora_membus_pkg::*;
#(
    parameter int PHI1_CYC = 3,
    parameter int PHI2_CYC = 3
) (
    input  logic clk6x,
    input  logic rst,
    nora_cpu_membus_if.master bus
);

    localparam int CYC_LEN = PHI1_CYC + PHI2_CYC;
    localparam int PH_W    = $clog2(CYC_LEN);

    localparam logic [PH_W-1:0] PH_PHI1_LAST = PH_W'(PHI1_CYC - 1);
    localparam logic [PH_W-1:0] PH_LAST      = PH_W'(CYC_LEN - 1);
    // MWRn window: second PHI2 tick up to the second-to-last PHI2 tick
    localparam logic [PH_W-1:0] PH_WR_FIRST  = PH_W'(PHI1_CYC + 1);
    localparam logic [PH_W-1:0] PH_WR_LAST   = PH_W'(CYC_LEN - 2);

    typedef enum logic [1:0] {S_IDLE, S_PHI1, S_PHI2} state_t;

    state_t          state_reg, state_next;
    logic [PH_W-1:0] ph_reg, ph_next;

    target_t     dec_target;
    logic [8:0]  dec_mah;
    target_t     tgt_reg, tgt_cur;
    logic        rd_reg, rd_cur;
    logic        phi2_entry, in_phi2_next, sram_next;
    logic [7:0]  rd_data_next;

    logic        cphi2_reg, m1csn_reg, mrdn_reg, mwrn_reg;
    logic        cd_oe_reg, md_oe_reg, cyc_end_reg;
    logic [7:0]  cd_o_reg, md_o_reg, rambank_reg, rombank_reg;
    logic [8:0]  mah_reg;
    logic        csn_reg [3];

    nora_addr_decode u_decode (
        .ca_i      (bus.ca_i),
        .rambank_i (rambank_reg[5:0]),
        .rombank_i (rombank_reg[4:0]),
        .target_o  (dec_target),
        .mah_o     (dec_mah)
    );

    always_ff @(posedge clk6x) begin
        if (rst) begin
            state_reg <= S_IDLE;
            ph_reg    <= '0;
        end else begin
            state_reg <= state_next;
            ph_reg    <= ph_next;
        end
    end

    // run_i is only looked at in IDLE and at the wrap, so a cycle in flight
    // is never stretched or cut short.
    always_comb begin
        state_next = state_reg;
        ph_next    = ph_reg;
        case (state_reg)
            S_IDLE: begin
                ph_next = '0;
                if (bus.run_i) state_next = S_PHI1;
            end
            S_PHI1: begin
                ph_next = ph_reg + 1'b1;
                if (ph_reg == PH_PHI1_LAST) state_next = S_PHI2;
            end
            S_PHI2: begin
                if (ph_reg == PH_LAST) begin
                    ph_next    = '0;
                    state_next = bus.run_i ? S_PHI1 : S_IDLE;
                end else begin
                    ph_next = ph_reg + 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
                ph_next    = '0;
            end
        endcase
    end

    // On the entry edge the live decode is used; afterwards the captured one.
    assign phi2_entry   = (state_reg == S_PHI1) && (state_next == S_PHI2);
    assign in_phi2_next = (state_next == S_PHI2);
    assign tgt_cur      = phi2_entry ? dec_target : tgt_reg;
    assign rd_cur       = phi2_entry ? bus.crwn_i : rd_reg;
    assign sram_next    = in_phi2_next && (tgt_cur == T_SRAM);

    always_comb begin
        rd_data_next = 8'hFF;
        case (tgt_cur)
            T_SRAM:              rd_data_next = bus.md_i;
            T_RAMBANK:           rd_data_next = rambank_reg;
            T_ROMBANK:           rd_data_next = rombank_reg;
            T_VIA, T_VERA, T_AIO: rd_data_next = bus.io_rdata_i;
            default:             rd_data_next = 8'hFF;
        endcase
    end

    always_ff @(posedge clk6x) begin
        if (rst) begin
            tgt_reg     <= T_NONE;
            rd_reg      <= 1'b1;
            mah_reg     <= '0;
            cphi2_reg   <= 1'b0;
            m1csn_reg   <= 1'b1;
            mrdn_reg    <= 1'b1;
            mwrn_reg    <= 1'b1;
            cd_oe_reg   <= 1'b0;
            md_oe_reg   <= 1'b0;
            cd_o_reg    <= '0;
            md_o_reg    <= '0;
            cyc_end_reg <= 1'b0;
            rambank_reg <= '0;
            rombank_reg <= '0;
        end else begin
            if (phi2_entry) begin
                tgt_reg <= dec_target;
                rd_reg  <= bus.crwn_i;
                mah_reg <= dec_mah;
            end
            cphi2_reg   <= in_phi2_next;
            m1csn_reg   <= !sram_next;
            mrdn_reg    <= !(sram_next && rd_cur);
            mwrn_reg    <= !(sram_next && !rd_cur &&
                             ph_next >= PH_WR_FIRST && ph_next <= PH_WR_LAST);
            md_oe_reg   <= sram_next && !rd_cur;
            cd_oe_reg   <= in_phi2_next && rd_cur;
            cyc_end_reg <= in_phi2_next && (ph_next == PH_LAST);
            if (sram_next && !rd_cur) md_o_reg <= bus.cd_i;
            if (in_phi2_next && rd_cur) cd_o_reg <= rd_data_next;
            // Bank registers take CD at the end of the last PHI2 tick only,
            // so a cycle cut short by reset leaves them untouched.
            if (cyc_end_reg && !rd_reg) begin
                if (tgt_reg == T_RAMBANK) rambank_reg <= bus.cd_i;
                if (tgt_reg == T_ROMBANK) rombank_reg <= bus.cd_i;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_io_sel
            always_ff @(posedge clk6x) begin
                if (rst) csn_reg[gi] <= 1'b1;
                else     csn_reg[gi] <= !(in_phi2_next && tgt_cur == IO_SEL_TGT[gi]);
            end
        end
    endgenerate

    assign bus.cphi2_o    = cphi2_reg;
    assign bus.m1csn_o    = m1csn_reg;
    assign bus.mrdn_o     = mrdn_reg;
    assign bus.mwrn_o     = mwrn_reg;
    assign bus.cd_oe_o    = cd_oe_reg;
    assign bus.md_oe_o    = md_oe_reg;
    assign bus.cd_o       = cd_o_reg;
    assign bus.md_o       = md_o_reg;
    assign bus.mah_o      = mah_reg;
    assign bus.cyc_end_o  = cyc_end_reg;
    assign bus.rambank_o  = rambank_reg;
    assign bus.rombank_o  = rombank_reg;
    assign bus.via_csn_o  = csn_reg[0];
    assign bus.vera_csn_o = csn_reg[1];
    assign bus.aio_csn_o  = csn_reg[2];

endmodule

// File: tb/tb_nora_cpu_membus.sv
// Scoreboard bench for nora_cpu_membus: the stimulus process pushes the
// expected outcome of each CPU cycle, the monitor pops it on cyc_end_o.
module tb_nora_cpu_membus;

    localparam int TG_SRAM = 0, TG_RAMB = 1, TG_ROMB = 2, TG_VIA = 3,
                   TG_VERA = 4, TG_AIO = 5, TG_NONE = 6;

    logic clk6x = 1'b0;
    logic rst   = 1'b1;
    always #5 clk6x = ~clk6x;

    nora_cpu_membus_if bus ();

    nora_cpu_membus #(.PHI1_CYC(3), .PHI2_CYC(3)) dut (
        .clk6x (clk6x),
        .rst   (rst),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [15:0] addr;
        logic        wr;
        logic [7:0]  wdata;
        int          tgt;
        logic [8:0]  mah;
        logic [7:0]  rdata;
        logic        chk_data;
        logic        chk_low;
        logic [7:0]  ramb;
        logic [7:0]  romb;
    } txn_t;

    txn_t       exp_q [$];
    logic [7:0] m_ramb = 8'h00;
    logic [7:0] m_romb = 8'h00;
    logic [7:0] m_mem [int];
    logic [7:0] sram  [int];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] init_byte(input int phys);
        return phys[7:0] ^ phys[15:8] ^ {3'b000, phys[20:16]} ^ 8'h5A;
    endfunction

    function automatic int classify(input logic [15:0] a);
        if (a == 16'h0000) return TG_RAMB;
        if (a == 16'h0001) return TG_ROMB;
        if (a < 16'h9F00 || a >= 16'hA000) return TG_SRAM;
        if (a <= 16'h9F0F) return TG_VIA;
        if (a >= 16'h9F20 && a <= 16'h9F3F) return TG_VERA;
        if (a >= 16'h9F40 && a <= 16'h9F5F) return TG_AIO;
        return TG_NONE;
    endfunction

    function automatic logic [8:0] page_of(input logic [15:0] a, input logic [7:0] rb, input logic [7:0] ob);
        if (a >= 16'hC000) return {2'b11, ob[4:0], a[13:12]};
        if (a >= 16'hA000) return {2'b01, rb[5:0], a[12]};
        return {5'b00000, a[15:12]};
    endfunction

    // SRAM model: stores on any edge where the chip is selected with MWRn low,
    // and presents read data shortly after every edge.
    always @(posedge clk6x) begin : sram_model
        int phys;
        phys = int'({bus.mah_o, bus.ca_i[11:0]});
        if (bus.m1csn_o === 1'b0 && bus.mwrn_o === 1'b0) sram[phys] = bus.md_o;
        #1;
        phys = int'({bus.mah_o, bus.ca_i[11:0]});
        bus.md_i = sram.exists(phys) ? sram[phys] : init_byte(phys);
    end

    always @(negedge clk6x) begin : monitor
        logic       prev_hi = 1'b0;
        logic       phi1_bad = 1'b0;
        int         low_cnt = 0, hi_cnt = 0, m1_cnt = 0, rd_cnt = 0, via_cnt = 0;
        int         vera_cnt = 0, aio_cnt = 0, cdoe_cnt = 0, mdoe_cnt = 0, n = 0;
        logic [7:0] wr_mask = 8'h00, mdo_s = 8'h00;
        logic [8:0] mah_s = 9'h000;
        logic       is_sram;
        txn_t       t;
        if (bus.cphi2_o !== 1'b1) begin
            if (prev_hi) begin low_cnt = 0; phi1_bad = 1'b0; end
            low_cnt++;
            if (!bus.m1csn_o || !bus.mrdn_o || !bus.mwrn_o || !bus.via_csn_o ||
                !bus.vera_csn_o || !bus.aio_csn_o || bus.cd_oe_o || bus.md_oe_o || bus.cyc_end_o)
                phi1_bad = 1'b1;
        end else begin
            if (!prev_hi) begin
                hi_cnt = 0; m1_cnt = 0; rd_cnt = 0; via_cnt = 0; vera_cnt = 0;
                aio_cnt = 0; cdoe_cnt = 0; mdoe_cnt = 0; wr_mask = 8'h00;
                mah_s = bus.mah_o;
            end
            if (!bus.m1csn_o)   m1_cnt++;
            if (!bus.mrdn_o)    rd_cnt++;
            if (!bus.via_csn_o) via_cnt++;
            if (!bus.vera_csn_o) vera_cnt++;
            if (!bus.aio_csn_o) aio_cnt++;
            if (bus.cd_oe_o)    cdoe_cnt++;
            if (bus.md_oe_o)    mdoe_cnt++;
            if (!bus.mwrn_o && hi_cnt < 8) begin wr_mask[hi_cnt] = 1'b1; mdo_s = bus.md_o; end
            hi_cnt++;
            if (bus.cyc_end_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_cycle", 32'(exp_q.size()), 32'd1);
                end else begin
                    t = exp_q.pop_front();
                    n++;
                    is_sram = (t.tgt == TG_SRAM);
                    check("phi2_len", 32'(hi_cnt), 32'd3);
                    if (t.chk_low) check("phi1_len", 32'(low_cnt), 32'd3);
                    check("phi1_strobes_idle", 32'(phi1_bad), 32'd0);
                    check("m1csn_ticks", 32'(m1_cnt), (is_sram ? 32'd3 : 32'd0));
                    check("mrdn_ticks", 32'(rd_cnt), ((is_sram && !t.wr) ? 32'd3 : 32'd0));
                    check("mwrn_tick_mask", 32'(wr_mask), ((is_sram && t.wr) ? 32'h2 : 32'h0));
                    check("via_ticks", 32'(via_cnt), (t.tgt == TG_VIA ? 32'd3 : 32'd0));
                    check("vera_ticks", 32'(vera_cnt), (t.tgt == TG_VERA ? 32'd3 : 32'd0));
                    check("aio_ticks", 32'(aio_cnt), (t.tgt == TG_AIO ? 32'd3 : 32'd0));
                    check("cd_oe_ticks", 32'(cdoe_cnt), (t.wr ? 32'd0 : 32'd3));
                    check("md_oe_ticks", 32'(mdoe_cnt), ((is_sram && t.wr) ? 32'd3 : 32'd0));
                    if (is_sram) check("mah", 32'(mah_s), 32'(t.mah));
                    if (is_sram && t.wr) check("md_o", 32'(mdo_s), 32'(t.wdata));
                    if (!t.wr && t.chk_data) check("cd_o", 32'(bus.cd_o), 32'(t.rdata));
                    check("rambank", 32'(bus.rambank_o), 32'(t.ramb));
                    check("rombank", 32'(bus.rombank_o), 32'(t.romb));
                    $display("[TB] txn %0d addr=%h %s data=%h tgt=%0d cd_o=%h mah=%h",
                             n, t.addr, t.wr ? "WR" : "RD", t.wr ? t.wdata : t.rdata,
                             t.tgt, bus.cd_o, mah_s);
                end
            end
        end
        prev_hi = (bus.cphi2_o === 1'b1);
    end

    // Drive one CPU cycle starting from a PHI1/IDLE negedge and wait until it ends.
    task automatic do_txn(input logic [15:0] addr, input logic wr, input logic [7:0] wdata,
                          input logic from_idle, input logic stop_after);
        txn_t t;
        int   k;
        int   phys;
        logic [7:0] io;
        io             = 8'($urandom);
        bus.ca_i       = addr;
        bus.crwn_i     = !wr;
        bus.cd_i       = wr ? wdata : 8'($urandom);
        bus.io_rdata_i = io;
        t.addr = addr; t.wr = wr; t.wdata = wdata;
        t.tgt  = classify(addr);
        t.mah  = page_of(addr, m_ramb, m_romb);
        t.ramb = m_ramb; t.romb = m_romb;
        t.chk_low  = !from_idle;
        t.chk_data = 1'b1;
        phys = int'({t.mah, addr[11:0]});
        case (t.tgt)
            TG_SRAM: t.rdata = m_mem.exists(phys) ? m_mem[phys] : init_byte(phys);
            TG_RAMB: t.rdata = m_ramb;
            TG_ROMB: t.rdata = m_romb;
            TG_VIA:  t.rdata = io;
            TG_NONE: t.rdata = 8'hFF;
            default: begin t.rdata = 8'h00; t.chk_data = 1'b0; end
        endcase
        if (wr) begin
            if (t.tgt == TG_SRAM) m_mem[phys] = wdata;
            if (t.tgt == TG_RAMB) m_ramb = wdata;
            if (t.tgt == TG_ROMB) m_romb = wdata;
        end
        exp_q.push_back(t);
        if (stop_after) bus.run_i = 1'b0;
        if (from_idle)  bus.run_i = 1'b1;
        k = 0;
        while (bus.cphi2_o !== 1'b1 && k < 20) begin @(negedge clk6x); k++; end
        check("phi2_start_ticks", 32'(k), (from_idle ? 32'd4 : 32'd3));
        k = 0;
        while (bus.cyc_end_o !== 1'b1 && k < 20) begin @(negedge clk6x); k++; end
        check("cycle_timeout", 32'(k >= 20), 32'd0);
        @(negedge clk6x);
    endtask

    function automatic logic [15:0] rand_addr();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'h0001;
            2: return 16'($urandom_range(2, 5)) | (16'($urandom_range(0, 9)) << 12);
            3: return 16'hA000 | (16'($urandom_range(0, 1)) << 12) | 16'($urandom_range(0, 3));
            4: return 16'hC000 | (16'($urandom_range(0, 3)) << 12) | 16'($urandom_range(0, 3));
            5: return 16'h9F00 + 16'($urandom_range(0, 15));
            6: return 16'h9F20 + 16'($urandom_range(0, 63));
            default: return ($urandom_range(0, 1) == 0) ? 16'h9F10 + 16'($urandom_range(0, 15))
                                                        : 16'h9F60 + 16'($urandom_range(0, 159));
        endcase
    endfunction

    initial begin
        int k;
        bus.run_i = 1'b0; bus.ca_i = 16'h0000; bus.crwn_i = 1'b1;
        bus.cd_i = 8'h00; bus.io_rdata_i = 8'h00; bus.md_i = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk6x);
        check("rst_strobes", 32'({bus.m1csn_o, bus.mrdn_o, bus.mwrn_o, bus.via_csn_o,
                                  bus.vera_csn_o, bus.aio_csn_o}), 32'h3F);
        check("rst_clk_oe", 32'({bus.cphi2_o, bus.cd_oe_o, bus.md_oe_o, bus.cyc_end_o}), 32'h0);
        check("rst_mah_banks", 32'({bus.mah_o, bus.rambank_o, bus.rombank_o}), 32'h0);
        rst = 1'b0;
        k = 0;
        repeat (5) begin @(negedge clk6x); if (bus.cphi2_o !== 1'b0) k++; end
        check("idle_no_clock", 32'(k), 32'd0);

        // Directed cycles
        do_txn(16'h0010, 1'b1, 8'h12, 1'b1, 1'b0);
        do_txn(16'h0010, 1'b0, 8'h00, 1'b0, 1'b0);
        do_txn(16'h0000, 1'b1, 8'hAB, 1'b0, 1'b0);
        do_txn(16'h0001, 1'b1, 8'h0C, 1'b0, 1'b0);
        do_txn(16'h0000, 1'b0, 8'h00, 1'b0, 1'b0);
        do_txn(16'h0001, 1'b0, 8'h00, 1'b0, 1'b0);
        do_txn(16'hA123, 1'b0, 8'h00, 1'b0, 1'b0);
        do_txn(16'hC000, 1'b0, 8'h00, 1'b0, 1'b0);
        do_txn(16'hA123, 1'b1, 8'h5E, 1'b0, 1'b0);
        do_txn(16'hA123, 1'b0, 8'h00, 1'b0, 1'b0);
        do_txn(16'h9F02, 1'b0, 8'h00, 1'b0, 1'b0);
        do_txn(16'h9F20, 1'b1, 8'h33, 1'b0, 1'b0);
        do_txn(16'h9F80, 1'b0, 8'h00, 1'b0, 1'b0);

        // Freeze after the current cycle, then resume
        do_txn(16'h0010, 1'b0, 8'h00, 1'b0, 1'b1);
        k = 0;
        repeat (8) begin @(negedge clk6x); if (bus.cphi2_o !== 1'b0) k++; end
        check("frozen_clock_low", 32'(k), 32'd0);
        do_txn(16'h0010, 1'b0, 8'h00, 1'b1, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            do_txn(rand_addr(), 1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 1'b0);
        end

        // Reset in the middle of a ROMBANK write
        do_txn(16'h0001, 1'b1, 8'h0C, 1'b0, 1'b0);
        bus.ca_i = 16'h0001; bus.crwn_i = 1'b0; bus.cd_i = 8'h77;
        k = 0;
        while (bus.cphi2_o !== 1'b1 && k < 20) begin @(negedge clk6x); k++; end
        check("partial_write_started", 32'(bus.cphi2_o), 32'd1);
        rst = 1'b1;
        @(negedge clk6x);
        rst = 1'b0;
        check("midrst_strobes", 32'({bus.m1csn_o, bus.mrdn_o, bus.mwrn_o, bus.via_csn_o,
                                     bus.vera_csn_o, bus.aio_csn_o}), 32'h3F);
        check("midrst_clk_oe", 32'({bus.cphi2_o, bus.cd_oe_o, bus.md_oe_o, bus.cyc_end_o}), 32'h0);
        check("midrst_banks", 32'({bus.rambank_o, bus.rombank_o}), 32'h0);
        m_ramb = 8'h00;
        m_romb = 8'h00;
        do_txn(16'h0001, 1'b0, 8'h00, 1'b1, 1'b0);
        do_txn(16'hC123, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            do_txn(rand_addr(), 1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 1'b0);
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
